// File: rtl/nco_wave_sequencer_if.sv
// Bus bundle for the NCO waveform sequencer: table writes, run control,
// and the registered status/select outputs.
interface nco_wave_sequencer_if #(
  parameter int SELECT_WIDTH = 3,
  parameter int DEPTH        = 8,
  parameter int DUR_WIDTH    = 16
);
  localparam int AW = $clog2(DEPTH);

  logic                    wr_en;
  logic [AW-1:0]           wr_addr;
  logic [SELECT_WIDTH-1:0] wr_sel;
  logic [DUR_WIDTH-1:0]    wr_dur;
  logic [AW:0]             num_entries;
  logic                    loop_en;
  logic                    start;
  logic                    stop;
  logic [SELECT_WIDTH-1:0] signal_out;
  logic                    busy;
  logic                    done;
  logic [AW-1:0]           cur_idx;
  logic                    wr_err;
  logic                    start_err;

  // Controller side: programs the table and starts/stops the sequence.
  modport master (
    output wr_en, wr_addr, wr_sel, wr_dur, num_entries, loop_en, start, stop,
    input  signal_out, busy, done, cur_idx, wr_err, start_err
  );

  // Sequencer side.
  modport slave (
    input  wr_en, wr_addr, wr_sel, wr_dur, num_entries, loop_en, start, stop,
    output signal_out, busy, done, cur_idx, wr_err, start_err
  );
endinterface

// File: rtl/nco_wave_sequencer.sv
// NCO waveform sequencer: steps signal_out through a table of
// (select, duration) entries, one-shot or looped, with IDLE_SEL when idle.
module nco_wave_sequencer #(
  parameter int SELECT_WIDTH = 3,
  parameter int DEPTH        = 8,
  parameter int DUR_WIDTH    = 16,
  parameter int IDLE_SEL     = 0
) (
  input  logic clk,
  input  logic reset,
  nco_wave_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]             DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [SELECT_WIDTH-1:0] IDLE_W  = SELECT_WIDTH'(IDLE_SEL);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state_reg, state_next;

  logic [SELECT_WIDTH-1:0] sel_mem [DEPTH];
  logic [DUR_WIDTH-1:0]    dur_mem [DEPTH];

  logic [SELECT_WIDTH-1:0] sig_reg, sig_next;
  logic                    busy_reg, busy_next;
  logic                    done_reg, done_next;
  logic [AW-1:0]           idx_reg, idx_next;
  logic                    wr_err_reg, wr_err_next;
  logic                    start_err_reg, start_err_next;
  logic [DUR_WIDTH-1:0]    cnt_reg, cnt_next;
  logic [AW:0]             n_reg, n_next;

  logic                    wr_accept;
  logic [DEPTH-1:0]        wr_hit;
  logic [SELECT_WIDTH-1:0] sel0_eff;
  logic [DUR_WIDTH-1:0]    dur0_eff;
  logic [AW-1:0]           idx_inc;
  logic [AW:0]             last_idx;
  logic                    is_last;

  // Writes are only taken while idle; a busy write becomes an error pulse.
  assign wr_accept = bus.wr_en && (state_reg == IDLE);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_hit
      assign wr_hit[gi] = wr_accept && (bus.wr_addr == AW'(gi));
    end
  endgenerate

  // A write to entry 0 in the same cycle as start must be seen by that start.
  assign sel0_eff = wr_hit[0] ? bus.wr_sel : sel_mem[0];
  assign dur0_eff = wr_hit[0] ? bus.wr_dur : dur_mem[0];
  assign idx_inc  = idx_reg + 1'b1;
  assign last_idx = n_reg - 1'b1;
  assign is_last  = ({1'b0, idx_reg} == last_idx);

  // Table storage; cleared by reset, written only when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        sel_mem[i] <= '0;
        dur_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_hit[i]) begin
          sel_mem[i] <= bus.wr_sel;
          dur_mem[i] <= bus.wr_dur;
        end
      end
    end
  end

  // FSM state and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      sig_reg       <= IDLE_W;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      idx_reg       <= '0;
      wr_err_reg    <= 1'b0;
      start_err_reg <= 1'b0;
      cnt_reg       <= '0;
      n_reg         <= '0;
    end else begin
      state_reg     <= state_next;
      sig_reg       <= sig_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      idx_reg       <= idx_next;
      wr_err_reg    <= wr_err_next;
      start_err_reg <= start_err_next;
      cnt_reg       <= cnt_next;
      n_reg         <= n_next;
    end
  end

  // Next-state logic. An entry expires when its counter reaches 1 (or 0,
  // so a zero duration still holds for one cycle).
  always_comb begin
    state_next     = state_reg;
    sig_next       = sig_reg;
    busy_next      = busy_reg;
    done_next      = 1'b0;
    idx_next       = idx_reg;
    wr_err_next    = bus.wr_en && (state_reg == RUN);
    start_err_next = 1'b0;
    cnt_next       = cnt_reg;
    n_next         = n_reg;

    case (state_reg)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          if (bus.num_entries == '0) begin
            start_err_next = 1'b1;
          end else begin
            state_next = RUN;
            sig_next   = sel0_eff;
            busy_next  = 1'b1;
            idx_next   = '0;
            cnt_next   = dur0_eff;
            n_next     = (bus.num_entries > DEPTH_W) ? DEPTH_W : bus.num_entries;
          end
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_next = IDLE;
          sig_next   = IDLE_W;
          busy_next  = 1'b0;
          idx_next   = '0;
        end else if (cnt_reg <= DUR_WIDTH'(1)) begin
          if (!is_last) begin
            idx_next = idx_inc;
            sig_next = sel_mem[idx_inc];
            cnt_next = dur_mem[idx_inc];
          end else if (bus.loop_en) begin
            idx_next = '0;
            sig_next = sel_mem[0];
            cnt_next = dur_mem[0];
          end else begin
            state_next = IDLE;
            sig_next   = IDLE_W;
            busy_next  = 1'b0;
            done_next  = 1'b1;
            idx_next   = '0;
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        sig_next   = IDLE_W;
        busy_next  = 1'b0;
        idx_next   = '0;
      end
    endcase
  end

  assign bus.signal_out = sig_reg;
  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;
  assign bus.cur_idx    = idx_reg;
  assign bus.wr_err     = wr_err_reg;
  assign bus.start_err  = start_err_reg;
endmodule
